xs3_bcd_seq: RTL

Multi-digit Excess-3 to BCD/binary conversion sequencer. It accepts a packed word of DIGITS Excess-3 codes with a start/done handshake. It then time-shares a single 4-bit Excess-3 to BCD converter over the digits, most-significant digit first, one digit per clock. It assembles the packed BCD result, accumulates the binary value (acc = acc*10 + digit) and flags invalid codes. It sits between the lab input register bank and the display/arithmetic consumers.

---
 rtl/xs3_bcd_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/xs3_bcd_seq.sv
// xs3_bcd_seq
// Converts a packed word of DIGITS Excess-3 codes to packed BCD and to a
// binary value. A single Excess-3 decoder is shared across the digits,
// most-significant digit first, one digit per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   xs3_in     packed Excess-3 digits, MSD in the top nibble
//   busy       high from the cycle after accept through the done cycle
//   done       one-cycle completion pulse
//   bcd_out    packed BCD result (invalid digits read as 4'hF)
//   bin_out    binary value of the result (invalid digits count as 0)
//   err        at least one invalid code in the last transaction
//   err_digit  index (0 = LSD) of the most-significant invalid digit
module xs3_bcd_seq #(
  parameter  int DIGITS = 4,
  parameter  int BIN_W  = 14,
  localparam int EW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   xs3_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic [EW-1:0]         err_digit
);

  localparam int            W    = 4 * DIGITS;
  localparam logic [EW-1:0] LAST = EW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [EW-1:0]    cnt;
  logic [W-1:0]     shift_q;
  logic [W-1:0]     bcd_q;
  logic [BIN_W-1:0] acc_q;

  // Returns {valid, nibble}; invalid codes map to 4'hF.
  function automatic logic [4:0] xs3_decode(input logic [3:0] code);
    logic ok;
    ok = (code >= 4'd3) && (code <= 4'd12);
    return {ok, (ok ? (code - 4'd3) : 4'hF)};
  endfunction

  // acc*10 + d, with the multiply done as two shifts and an add.
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] acc,
                                             input logic [3:0]       d);
    return (acc << 3) + (acc << 1) + BIN_W'(d);
  endfunction

  logic [4:0]       dec;
  logic             dig_ok;
  logic [3:0]       dig_bcd;
  logic [3:0]       dig_val;
  logic [W-1:0]     bcd_nxt;
  logic [BIN_W-1:0] acc_nxt;
  logic             last;

  assign dec     = xs3_decode(shift_q[W-1 -: 4]);
  assign dig_ok  = dec[4];
  assign dig_bcd = dec[3:0];
  assign dig_val = dig_ok ? dig_bcd : 4'd0;
  assign bcd_nxt = (bcd_q << 4) | W'(dig_bcd);
  assign acc_nxt = mac10(acc_q, dig_val);
  assign last    = (cnt == LAST);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:               state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // Control and visible results: counter, error capture, final output load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bcd_out   <= '0;
      bin_out   <= '0;
      err       <= 1'b0;
      err_digit <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            err       <= 1'b0;
            err_digit <= '0;
          end
        end
        CONV: begin
          cnt <= last ? '0 : cnt + EW'(1);
          // Only the first invalid digit of a transaction is recorded.
          if (!dig_ok && !err) begin
            err       <= 1'b1;
            err_digit <= LAST - cnt;
          end
          if (last) begin
            bcd_out <= bcd_nxt;
            bin_out <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Working datapath: input shift register, BCD assembly, binary accumulator.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      shift_q <= xs3_in;
      bcd_q   <= '0;
      acc_q   <= '0;
    end else if (state == CONV) begin
      shift_q <= shift_q << 4;
      bcd_q   <= bcd_nxt;
      acc_q   <= acc_nxt;
    end
  end

endmodule
